// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 12_000_000;
    localparam int DEFAULT_BAUD_RATE = 9600;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; occupancy count doubles as the full/empty source.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in sync_fifo and are serialised back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        hw_clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        uarttx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = width_of(CLKS_PER_BIT);
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              line_busy_q, line_busy_d;
    logic              fifo_push, fifo_pop, fifo_empty, baud_done;
    logic [7:0]        fifo_rdata;

    assign in_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_push  = in_valid && in_ready;
    assign fifo_empty = (fifo_count == '0);
    assign baud_done  = (baud_q == BAUD_LAST);

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (hw_clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                baud_d = baud_q + 1'b1;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 1'b1;
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                baud_d = baud_q + 1'b1;
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame so the line never idles between bytes.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        bit_d    = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows state one cycle later, so every level is held exactly CLKS_PER_BIT.
    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        line_busy_d = (state_q != IDLE);
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            tx_q        <= 1'b1;
            line_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            line_busy_q <= line_busy_d;
        end
    end

    always_ff @(posedge hw_clk) begin
        shift_q <= shift_d;
    end

    assign uarttx = tx_q;
    assign busy   = line_busy_q || (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: occupancy/timing reference model plus a serial line decoder.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 16;

    logic       hw_clk   = 1'b0;
    logic       rst_n    = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, uarttx, busy;
    logic [4:0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ   (40),
        .BAUD_RATE  (10),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .hw_clk     (hw_clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .uarttx     (uarttx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 hw_clk = ~hw_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle", tag, got, exp);
        end
    endtask

    // Reference model: a byte is popped at the first edge where the buffer is
    // non-empty and the previous frame (started FRAME cycles earlier) is over.
    int         cyc        = 0;
    int         m_count    = 0;
    int         m_next_pop = 0;
    int         m_last_pop = -1000;
    bit         m_acc      = 1'b0;
    logic [7:0] exp_bytes[$];
    int         exp_start[$];
    int         n_acc = 0, n_rx = 0, n_discard = 0, n_starts = 0;
    int         dut_max = 0, stall_cycles = 0;

    always @(posedge hw_clk) begin : model
        bit pop;
        cyc++;
        if (!rst_n) begin
            n_discard += exp_bytes.size();
            exp_bytes.delete();
            exp_start.delete();
            m_count    = 0;
            m_next_pop = 0;
            m_last_pop = -1000;
            m_acc      = 1'b0;
        end else begin
            pop   = (m_count > 0) && (cyc >= m_next_pop);
            m_acc = in_valid && (m_count != DEPTH);
            if (m_acc) begin
                exp_bytes.push_back(in_data);
                n_acc++;
            end
            if (pop) begin
                m_next_pop = cyc + FRAME;
                m_last_pop = cyc;
                exp_start.push_back(cyc + 1);
            end
            m_count = m_count + int'(m_acc) - int'(pop);
        end
    end

    bit          rx_active = 1'b0;
    int          rx_start  = 0;
    logic [39:0] samp;

    always @(negedge hw_clk) begin : checker_and_decoder
        int         k;
        bit         ok;
        logic [7:0] rx;
        chk("fifo_count", 32'(fifo_count), m_count);
        chk("in_ready", 32'(in_ready), 32'(m_count != DEPTH));
        chk("busy", 32'(busy), 32'((m_count != 0) || (cyc <= m_last_pop + FRAME)));
        if (int'(fifo_count) > dut_max) dut_max = int'(fifo_count);
        if (in_valid && !in_ready) stall_cycles++;
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (rx_active) begin
            k = cyc - rx_start;
            samp[k] = uarttx;
            if (k == FRAME - 1) begin
                rx_active = 1'b0;
                ok = (samp[0] == 1'b0) && (samp[36] == 1'b1);
                for (int i = 0; i < 10; i++)
                    for (int j = 1; j < CPB; j++)
                        if (samp[CPB*i+j] !== samp[CPB*i]) ok = 1'b0;
                chk("frame_shape", 32'(ok), 32'd1);
                for (int n = 0; n < 8; n++) rx[n] = samp[CPB*(n+1)];
                if (exp_bytes.size() == 0) begin
                    chk("byte_pending", exp_bytes.size(), 32'd1);
                end else begin
                    chk("rx_byte", 32'(rx), 32'(exp_bytes.pop_front()));
                    n_rx++;
                end
            end
        end else if (uarttx === 1'b0) begin
            rx_active = 1'b1;
            rx_start  = cyc;
            samp[0]   = 1'b0;
            n_starts++;
            if (exp_start.size() == 0) chk("start_pending", exp_start.size(), 32'd1);
            else chk("start_cyc", cyc, exp_start.pop_front());
        end
    end

    task automatic push(input logic [7:0] b);
        int i = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge hw_clk);
            i++;
        end while (!m_acc && i < 2000);
        chk("push_accept", 32'(m_acc), 32'd1);
    endtask

    task automatic drain();
        int i = 0;
        in_valid = 1'b0;
        while (!(m_count == 0 && exp_bytes.size() == 0 && exp_start.size() == 0 &&
                 cyc > m_last_pop + FRAME + 1) && i < 3000) begin
            @(negedge hw_clk);
            i++;
        end
        chk("drained", exp_bytes.size(), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin : stimulus
        logic [7:0] burst[4];
        int         cnt_before, starts_before, w;
        burst = '{8'h31, 8'h32, 8'h33, 8'h0A};

        #1 rst_n = 1'b0;
        #1;
        chk("rst_uarttx", 32'(uarttx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge hw_clk);
        #1 rst_n = 1'b1;

        @(negedge hw_clk);
        push(8'h35);
        drain();

        @(negedge hw_clk);
        foreach (burst[i]) push(burst[i]);
        drain();

        // Time a push onto the exact edge where the transmitter pops.
        @(negedge hw_clk);
        push(8'hA5);
        in_valid = 1'b0;
        @(negedge hw_clk);
        push(8'h5A);
        in_valid = 1'b0;
        w = 0;
        while (cyc + 1 != m_next_pop && w < 200) begin
            @(negedge hw_clk);
            w++;
        end
        cnt_before = m_count;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge hw_clk);
        chk("pushpop_cnt", 32'(fifo_count), cnt_before);
        in_valid = 1'b0;
        drain();

        dut_max      = 0;
        stall_cycles = 0;
        @(negedge hw_clk);
        for (int i = 0; i < 18; i++) push(8'($urandom));
        in_valid = 1'b0;
        chk("full_peak", dut_max, DEPTH);
        chk("stall_seen", 32'(stall_cycles > 0), 32'd1);
        drain();

        @(negedge hw_clk);
        for (int i = 0; i < 6; i++) push(8'($urandom));
        in_valid = 1'b0;
        w = 0;
        while (!(rx_active && (cyc - rx_start) == 17) && w < 300) begin
            @(negedge hw_clk);
            w++;
        end
        chk("queued_before_rst", 32'(fifo_count), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_uarttx", 32'(uarttx), 32'd1);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge hw_clk);
        #1 rst_n = 1'b1;
        starts_before = n_starts;
        repeat (100) @(negedge hw_clk);
        chk("no_start_after_rst", n_starts - starts_before, 32'd0);
        chk("line_idle_after_rst", 32'(uarttx), 32'd1);
        push(8'h7E);
        drain();

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat ($urandom_range(1, 60)) @(negedge hw_clk);
            end
            push(8'($urandom));
        end
        drain();

        chk("rx_total", n_rx, n_acc - n_discard);
        chk("start_queue_empty", exp_start.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
